wb_queue: RTL and testbench



---
 rtl/wb_queue.sv | 106 ++++++++++
 tb/tb_wb_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// In-order write-back queue merging two producers into one register-file write port,
// with read-after-write pending lookup. Define WBQ_FORWARD_EN to add youngest-match forwarding outputs.
module wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DEPTH      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid_A,
  input  logic [REG_WIDTH-1:0]      i_reg_A,
  input  logic [DATA_WIDTH-1:0]     i_data_A,
  output logic                      o_ready_A,
  input  logic                      i_valid_B,
  input  logic [REG_WIDTH-1:0]      i_reg_B,
  input  logic [DATA_WIDTH-1:0]     i_data_B,
  output logic                      o_ready_B,
  output logic                      o_we,
  output logic [REG_WIDTH-1:0]      o_wr_reg,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  input  logic [REG_WIDTH-1:0]      i_rd_reg_A,
  output logic                      o_pend_A,
  input  logic [REG_WIDTH-1:0]      i_rd_reg_B,
  output logic                      o_pend_B,
  output logic [$clog2(DEPTH):0]    o_count
`ifdef WBQ_FORWARD_EN
  ,
  output logic [DATA_WIDTH-1:0]     o_fwd_data_A,
  output logic [DATA_WIDTH-1:0]     o_fwd_data_B
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_WIDTH-1:0]  mem_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_b;
  logic [CW-1:0]         count, free;
  logic                  push_A, push_B, pop;

  // Free space uses the registered count only; a same-cycle pop is not credited.
  assign free      = CW'(DEPTH) - count;
  assign o_ready_A = (free >= CW'(1));
  assign o_ready_B = (free >= CW'(2)) | ((free == CW'(1)) & ~i_valid_A);

  // Register 0 completes the handshake but never occupies a slot.
  assign push_A   = i_valid_A & o_ready_A & (i_reg_A != '0);
  assign push_B   = i_valid_B & o_ready_B & (i_reg_B != '0);
  assign pop      = (count != '0);
  assign wr_ptr_b = wr_ptr + PW'(push_A);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_A) begin
        mem_reg[wr_ptr]  <= i_reg_A;
        mem_data[wr_ptr] <= i_data_A;
      end
      if (push_B) begin
        mem_reg[wr_ptr_b]  <= i_reg_B;
        mem_data[wr_ptr_b] <= i_data_B;
      end
      wr_ptr <= wr_ptr + PW'(push_A) + PW'(push_B);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_A) + CW'(push_B) - CW'(pop);
    end
  end

  assign o_we      = pop;
  assign o_wr_reg  = pop ? mem_reg[rd_ptr]  : '0;
  assign o_wr_data = pop ? mem_data[rd_ptr] : '0;
  assign o_count   = count;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    logic          occ;
    o_pend_A = 1'b0;
    o_pend_B = 1'b0;
`ifdef WBQ_FORWARD_EN
    o_fwd_data_A = '0;
    o_fwd_data_B = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      occ = (CW'(k) < count);
      if (occ && (mem_reg[idx] == i_rd_reg_A) && (i_rd_reg_A != '0)) begin
        o_pend_A = 1'b1;
`ifdef WBQ_FORWARD_EN
        o_fwd_data_A = mem_data[idx];
`endif
      end
      if (occ && (mem_reg[idx] == i_rd_reg_B) && (i_rd_reg_B != '0)) begin
        o_pend_B = 1'b1;
`ifdef WBQ_FORWARD_EN
        o_fwd_data_B = mem_data[idx];
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: vector table plus scoreboard of expected register-file writes.
module tb_wb_queue;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int DEPTH = 4;

  logic          i_clk, i_rst;
  logic          i_valid_A, i_valid_B;
  logic [RW-1:0] i_reg_A, i_reg_B, i_rd_reg_A, i_rd_reg_B;
  logic [DW-1:0] i_data_A, i_data_B;
  logic          o_ready_A, o_ready_B, o_we, o_pend_A, o_pend_B;
  logic [RW-1:0] o_wr_reg;
  logic [DW-1:0] o_wr_data;
  logic [$clog2(DEPTH):0] o_count;
`ifdef WBQ_FORWARD_EN
  logic [DW-1:0] o_fwd_data_A, o_fwd_data_B;
`endif

  wb_queue #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid_A(i_valid_A), .i_reg_A(i_reg_A), .i_data_A(i_data_A), .o_ready_A(o_ready_A),
    .i_valid_B(i_valid_B), .i_reg_B(i_reg_B), .i_data_B(i_data_B), .o_ready_B(o_ready_B),
    .o_we(o_we), .o_wr_reg(o_wr_reg), .o_wr_data(o_wr_data),
    .i_rd_reg_A(i_rd_reg_A), .o_pend_A(o_pend_A),
    .i_rd_reg_B(i_rd_reg_B), .o_pend_B(o_pend_B),
    .o_count(o_count)
`ifdef WBQ_FORWARD_EN
    , .o_fwd_data_A(o_fwd_data_A), .o_fwd_data_B(o_fwd_data_B)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;
  ent_t sb[$];

  typedef struct {
    logic          va;
    logic [RW-1:0] ra;
    logic [DW-1:0] da;
    logic          vb;
    logic [RW-1:0] rb;
    logic [DW-1:0] db;
    logic [RW-1:0] rda;
    logic [RW-1:0] rdb;
    logic          exp_ra;
    logic          exp_rb;
    int            exp_cnt;
  } vec_t;
  vec_t vecs[10];

  int  checks = 0;
  int  errors = 0;
  logic last_acc_A, last_acc_B;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic step();
    int   free;
    logic exp_pa, exp_pb, exp_rdy_a, exp_rdy_b;
    logic [DW-1:0] fa, fb;
    #1;
    chk("count", 32'(o_count), 32'(sb.size()));
    chk("count_le_depth", 32'(o_count <= DEPTH), 32'd1);
    chk("we", 32'(o_we), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("wr_reg", 32'(o_wr_reg), 32'(sb[0].r));
      chk("wr_data", o_wr_data, sb[0].d);
    end else begin
      chk("wr_reg_idle", 32'(o_wr_reg), 32'd0);
      chk("wr_data_idle", o_wr_data, 32'd0);
    end
    exp_pa = 1'b0; exp_pb = 1'b0; fa = '0; fb = '0;
    foreach (sb[i]) begin
      if (sb[i].r == i_rd_reg_A && i_rd_reg_A != 0) begin exp_pa = 1'b1; fa = sb[i].d; end
      if (sb[i].r == i_rd_reg_B && i_rd_reg_B != 0) begin exp_pb = 1'b1; fb = sb[i].d; end
    end
    chk("pend_A", 32'(o_pend_A), 32'(exp_pa));
    chk("pend_B", 32'(o_pend_B), 32'(exp_pb));
`ifdef WBQ_FORWARD_EN
    chk("fwd_A", o_fwd_data_A, fa);
    chk("fwd_B", o_fwd_data_B, fb);
`endif
    free = DEPTH - sb.size();
    exp_rdy_a = (free >= 1);
    exp_rdy_b = (free >= 2) || (free == 1 && !i_valid_A);
    chk("ready_A", 32'(o_ready_A), 32'(exp_rdy_a));
    chk("ready_B", 32'(o_ready_B), 32'(exp_rdy_b));
    last_acc_A = i_valid_A && exp_rdy_a;
    last_acc_B = i_valid_B && exp_rdy_b;
    if (sb.size() != 0) void'(sb.pop_front());
    if (last_acc_A && i_reg_A != 0) sb.push_back('{i_reg_A, i_data_A});
    if (last_acc_B && i_reg_B != 0) sb.push_back('{i_reg_B, i_data_B});
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_valid_A = 1'b0; i_valid_B = 1'b0;
    i_reg_A = '0; i_reg_B = '0; i_data_A = '0; i_data_B = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 1};
    vecs[2] = '{1'b1, 5'd5, 32'hA,  1'b1, 5'd5, 32'hB, 5'd0, 5'd0, 1'b1, 1'b1, 0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b1, 2};
    vecs[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b1, 1};
    vecs[5] = '{1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 0};
    vecs[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 0};
    vecs[7] = '{1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b1, 0};
    vecs[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b1, 1};
    vecs[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b1, 0};

    idle();
    i_rd_reg_A = '0; i_rd_reg_B = '0;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_ready_A", 32'(o_ready_A), 32'd1);
    chk("rst_ready_B", 32'(o_ready_B), 32'd1);
    @(negedge i_clk);

    // Single write, same-register pair, register 0, pending tracking.
    for (int i = 0; i < 10; i++) begin
      i_valid_A = vecs[i].va; i_reg_A = vecs[i].ra; i_data_A = vecs[i].da;
      i_valid_B = vecs[i].vb; i_reg_B = vecs[i].rb; i_data_B = vecs[i].db;
      i_rd_reg_A = vecs[i].rda; i_rd_reg_B = vecs[i].rdb;
      #1;
      chk($sformatf("vec%0d_ready_A", i), 32'(o_ready_A), 32'(vecs[i].exp_ra));
      chk($sformatf("vec%0d_ready_B", i), 32'(o_ready_B), 32'(vecs[i].exp_rb));
      chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].exp_cnt));
      step();
    end
    idle();
    i_rd_reg_A = '0;

    // Both ports saturating: A carries odd regs, B even regs; hold until accepted.
    begin
      int ia, ib, cyc;
      ia = 1; ib = 2; cyc = 0;
      while ((ia <= 7 || ib <= 8) && cyc < 40) begin
        i_valid_A = (ia <= 7); i_reg_A = RW'(ia <= 7 ? ia : 0); i_data_A = 32'h300 + 32'(ia);
        i_valid_B = (ib <= 8); i_reg_B = RW'(ib <= 8 ? ib : 0); i_data_B = 32'h300 + 32'(ib);
        i_rd_reg_A = 5'd4; i_rd_reg_B = 5'd7;
        step();
        if (last_acc_A) ia += 2;
        if (last_acc_B) ib += 2;
        cyc++;
      end
      chk("sat_all_accepted", 32'(ia > 7 && ib > 8), 32'd1);
      idle();
      for (int i = 0; i < 6; i++) step();
      chk("sat_drained", 32'(o_count), 32'd0);
    end

    // Reset with three entries queued: nothing may be written afterwards.
    i_rd_reg_A = 5'd9; i_rd_reg_B = 5'd12;
    i_valid_A = 1'b1; i_reg_A = 5'd9;  i_data_A = 32'h99;
    i_valid_B = 1'b1; i_reg_B = 5'd10; i_data_B = 32'hAA;
    step();
    i_reg_A = 5'd11; i_data_A = 32'hBB; i_reg_B = 5'd12; i_data_B = 32'hCC;
    step();
    idle();
    #1;
    chk("pre_rst_count", 32'(o_count), 32'd3);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    sb.delete();
    #1;
    chk("post_rst_we", 32'(o_we), 32'd0);
    chk("post_rst_count", 32'(o_count), 32'd0);
    chk("post_rst_pend_B", 32'(o_pend_B), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    for (int i = 0; i < 5; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
